// File: rtl/delay_line.sv
// Programmable delay line: ring of {valid,data} entries read D slots behind
// the write pointer, with a settle phase that flushes the ring on delay change.
module delay_line #(
  parameter int WIDTH     = 8,
  parameter int MAX_DEPTH = 16,
  localparam int DW       = $clog2(MAX_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] to_delay,
  input  logic             to_delay_valid,
  input  logic             hold,
  input  logic [DW-1:0]    delay_sel,
  output logic [WIDTH-1:0] delayed,
  output logic             delayed_valid,
  output logic             settling,
  output logic [DW-1:0]    in_flight
);

  localparam int PW = $clog2(MAX_DEPTH);
  localparam logic [DW:0] MD =
    (DW+1)'(MAX_DEPTH);
  localparam logic [PW-1:0] LAST =
    PW'(MAX_DEPTH - 1);

  typedef enum logic {
    RUN,
    SETTLE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]     ring_d [MAX_DEPTH];
  logic [MAX_DEPTH-1:0] ring_v;
  logic [PW-1:0]        wp;
  logic [PW-1:0]        rd_idx;
  logic [DW:0]          rd_sum;
  logic [DW-1:0]        cur_d;
  logic [DW-1:0]        sel_d;
  logic [DW-1:0]        cnt;
  logic                 active;
  logic                 chg;
  logic                 emit;
  logic                 last_settle;

  // Clamp the requested delay into 1..MAX_DEPTH.
  always_comb begin
    sel_d = delay_sel;
    if (delay_sel == '0)
      sel_d = DW'(1);
    else if ({1'b0, delay_sel} > MD)
      sel_d = MD[DW-1:0];
  end

  // Qualifiers and read slot, cur_d entries behind the write pointer.
  always_comb begin
    active = !rst && !hold;
    chg    = active && (sel_d != cur_d);
    rd_sum = {1'b0, DW'(wp)} + MD
           - {1'b0, cur_d};
    if (rd_sum >= MD)
      rd_sum = rd_sum - MD;
    rd_idx = PW'(rd_sum);
    last_settle = (state == SETTLE)
               && (cnt == DW'(1));
    emit = ring_v[rd_idx]
        && ((state == RUN) || last_settle);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= RUN;
    else
      state <= state_nxt;
  end

  // FSM next state: enter SETTLE on change, leave when the count expires.
  always_comb begin
    state_nxt = state;
    if (chg)
      state_nxt = SETTLE;
    else if (active && last_settle)
      state_nxt = RUN;
  end

  // FSM outputs.
  always_comb begin
    settling = (state == SETTLE);
  end

  // Ring data storage; contents of invalid slots are never observed.
  always_ff @(posedge clk) begin
    if (active)
      ring_d[wp] <= to_delay;
  end

  // Pointer, valid bits, stored delay, settle counter and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp            <= '0;
      ring_v        <= '0;
      cur_d         <= sel_d;
      cnt           <= '0;
      delayed       <= '0;
      delayed_valid <= 1'b0;
      in_flight     <= '0;
    end else if (active) begin
      wp      <= (wp == LAST) ? '0 : wp + PW'(1);
      delayed <= ring_d[rd_idx];
      if (chg) begin
        ring_v        <= '0;
        cur_d         <= sel_d;
        cnt           <= sel_d;
        delayed_valid <= 1'b0;
        in_flight     <= DW'(to_delay_valid);
      end else begin
        if (state == SETTLE)
          cnt <= cnt - DW'(1);
        delayed_valid <= emit;
        in_flight     <= in_flight
                       + DW'(to_delay_valid)
                       - DW'(emit);
      end
      ring_v[wp] <= to_delay_valid;
    end
  end

endmodule

// File: doc/delay_line.md
DELAY_LINE -- requirements
Module: delay_line

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits (>=1).
REQ-002 Parameter MAX_DEPTH, default 16, largest selectable delay in clock cycles (>=2, need not be a power of two).
REQ-003 Localparam DW = clog2(MAX_DEPTH+1), width of delay select and occupancy count.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 to_delay  input  WIDTH  sample to be delayed.
REQ-007 to_delay_valid  input  1  qualifies to_delay in the same cycle.
REQ-008 hold  input  1  freeze: line neither advances nor accepts input while high.
REQ-009 delay_sel  input  DW  requested delay in cycles.
REQ-010 delayed  output  WIDTH  delayed sample, registered.
REQ-011 delayed_valid  output  1  qualifies delayed, registered.
REQ-012 settling  output  1  high while line refills after a delay change.
REQ-013 in_flight  output  DW  count of valid samples currently inside the line.

Function
REQ-014 Effective delay D SHALL be clamp(delay_sel): 0 -> 1, >MAX_DEPTH -> MAX_DEPTH, otherwise delay_sel.
REQ-015 Storage SHALL be a ring of MAX_DEPTH entries of {valid, data}, with a write pointer wrapping from MAX_DEPTH-1 to 0.
REQ-016 An active cycle is a cycle with rst=0 and hold=0; only active cycles write the ring, advance the pointer and update outputs.
REQ-017 A sample presented on active edge k SHALL appear on delayed/delayed_valid exactly D active edges later (edge k+D with no hold).
REQ-018 Samples presented with to_delay_valid=0 SHALL emerge with delayed_valid=0; delayed is don't-care when delayed_valid=0.
REQ-019 While hold=1 all outputs, ring contents, pointer and counters SHALL hold their values; to_delay is ignored.
REQ-020 The stored delay cur_D SHALL be compared with clamp(delay_sel) only on active cycles; a change while hold=1 is acted on at the first active cycle.
REQ-021 FSM states RUN and SETTLE; reset enters RUN.
REQ-022 RUN -> SETTLE on an active cycle where clamp(delay_sel) != cur_D: load cur_D, clear all ring valid bits, write the current input (with its valid) to the ring, load settle counter with new D.
REQ-023 SETTLE: settling=1, delayed_valid=0; counter decrements once per active cycle; -> RUN on the cycle it reaches 0, so the first post-change sample emerges on the first RUN cycle.
REQ-024 A further delay change during SETTLE SHALL restart the REQ-022 sequence with the newest value.
REQ-025 in_flight SHALL increment on an accepted valid input, decrement on an emitted valid output, remain unchanged when both occur, and never exceed D.
REQ-026 On a delay change in_flight SHALL become 1 if the input in that cycle is valid, else 0.
REQ-027 No X may propagate to delayed_valid, settling or in_flight after reset.

Reset
REQ-028 On an rst=1 edge: delayed=0, delayed_valid=0, settling=0, in_flight=0, all ring valid bits=0, pointer=0, state=RUN, cur_D=clamp(delay_sel).
REQ-029 rst SHALL take priority over hold and over any delay change; reset mid-operation discards all in-flight samples.
REQ-030 The first sample presented after reset deasserts SHALL emerge D cycles later with no settling phase.

Verification (WIDTH=8, MAX_DEPTH=16)
REQ-031 delay_sel=5, ramp 0x01..0x0A valid on consecutive edges -> 0x01 valid on edge 5 after its input, then one sample per cycle, in_flight steady at 5.
REQ-032 delay_sel=0 then 20 -> observed delay 1 then 16; pointer wrap exercised by 40 continuous samples, no data loss.
REQ-033 delay_sel=3, samples 0xA0..0xA3, hold high for 4 cycles mid-stream -> outputs frozen, sequence resumes unbroken, total latency 3+4.
REQ-034 Running at D=4, switch delay_sel to 8 -> settling high for 8 cycles, delayed_valid=0 throughout, first new sample emerges at 8 cycles, old samples never emitted.
REQ-035 Change delay 4->8 then 8->2 two cycles later -> settle restarts, settling high 2 cycles after the second change.
REQ-036 rst pulsed with 3 samples in flight at D=6 -> next edge all outputs 0, in_flight=0, no stale sample ever emerges.
